// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer placing a fetch port and a load/store port onto one
// single-port RAM with a registered read output; byte addresses become word addresses.
module ram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [31:0]       p0_addr,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, READ, DONE} state_t;

  state_t             state;
  logic               last;
  logic               we_q;
  logic [CNT_W-1:0]   cnt;

  logic               gnt_valid;
  logic               gnt;
  logic [31:0]        g_addr;
  logic               g_we;
  logic [DATA_W-1:0]  g_wdata;
  logic               g_bad;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    gnt_valid = p0_req | p1_req;
    gnt       = (p0_req && p1_req) ? ~last : p1_req;
    g_addr    = gnt ? p1_addr : p0_addr;
    g_we      = gnt & p1_we;
    g_wdata   = gnt ? p1_wdata : '0;
    g_bad     = (|g_addr[1:0]) || (|g_addr[31:ADDR_W+2]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      we_q     <= 1'b0;
      cnt      <= '0;
      p0_done  <= 1'b0;
      p0_rdata <= '0;
      p0_err   <= 1'b0;
      p1_done  <= 1'b0;
      p1_rdata <= '0;
      p1_err   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      busy     <= 1'b0;
      owner    <= 1'b0;
    end else begin
      p0_done <= 1'b0;
      p0_err  <= 1'b0;
      p1_done <= 1'b0;
      p1_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner <= gnt;
            last  <= gnt;
            busy  <= 1'b1;
            we_q  <= g_we;
            if (g_bad) begin
              // Rejected accesses never touch the RAM and complete immediately.
              if (gnt) begin
                p1_done <= 1'b1;
                p1_err  <= 1'b1;
              end else begin
                p0_done <= 1'b1;
                p0_err  <= 1'b1;
              end
              state <= DONE;
            end else begin
              ram_addr <= g_addr[ADDR_W+1:2];
              ram_din  <= g_wdata;
              ram_we   <= g_we;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          ram_we <= 1'b0;
          cnt    <= CNT_W'(RD_LAT - 1);
          state  <= READ;
        end
        READ: begin
          if (cnt == '0) begin
            if (owner) begin
              p1_done <= 1'b1;
              if (!we_q) p1_rdata <= ram_dout;
            end else begin
              p0_done <= 1'b1;
              if (!we_q) p0_rdata <= ram_dout;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          owner <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural RAM, a directed driver and a
// scoreboard monitor that checks each done pulse against queued expectations.
module tb_ram_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 1;
  localparam int W      = 35;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              p0_req = 1'b0;
  logic [31:0]       p0_addr = '0;
  logic              p0_done;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_err;
  logic              p1_req = 1'b0;
  logic              p1_we = 1'b0;
  logic [31:0]       p1_addr = '0;
  logic [DATA_W-1:0] p1_wdata = '0;
  logic              p1_done;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_err;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout = '0;
  logic              busy;
  logic              owner;

  logic [DATA_W-1:0] mem [0:1023] = '{default: '0};
  logic [W-1:0]      exp_q[$];
  int                exp_cyc_q[$];
  int                tests = 0;
  int                fails = 0;
  int                cyc = 0;
  int                we_cnt = 0;
  logic [ADDR_W-1:0] exp_ram_addr = '0;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .owner(owner)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read-first, registered output, word 1 preloaded on the first edge
  always @(posedge clk) begin
    if (cyc == 0) mem[1] <= 32'h12345678;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) if (ram_we) we_cnt <= we_cnt + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && (p0_done || p1_done)) begin
      if (p0_done && p1_done) begin
        check("both_done", 2'b11, 2'b01);
      end else if (exp_q.size() == 0) begin
        check("unexpected_done", {p1_done, p0_done}, 2'b00);
      end else begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        int           ecyc;
        act  = p1_done ? {1'b1, owner, p1_err, p1_rdata} : {1'b0, owner, p0_err, p0_rdata};
        exp  = exp_q.pop_front();
        ecyc = exp_cyc_q.pop_front();
        check("done_port_owner_err_rdata", act, exp);
        check("done_cycle", cyc, ecyc);
      end
    end
  end

  // driver: called at a negedge with the DUT idle; returns at a negedge in IDLE
  task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit exp_err, input logic [31:0] exp_data);
    int e;
    int we0;
    bit seen;
    seen = 1'b0;
    we0  = we_cnt;
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_addr = addr;
    end
    @(posedge clk); #1;
    e = cyc;
    exp_q.push_back({port, port, exp_err, exp_data});
    exp_cyc_q.push_back(exp_err ? e : e + RD_LAT + 1);
    if (!exp_err) exp_ram_addr = addr[ADDR_W+1:2];
    check("issue_busy_owner_we_addr", {busy, owner, ram_we, ram_addr},
          {1'b1, port, we & ~exp_err, exp_ram_addr});
    if (we && !exp_err) check("issue_din", ram_din, wdata);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? p1_done : p0_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    p0_req = 1'b0;
    p1_req = 1'b0;
    p1_we  = 1'b0;
    check("we_cycles", we_cnt - we0, (we && !exp_err) ? 1 : 0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {p0_done, p0_err, p0_rdata, p1_done, p1_err, p1_rdata,
                 ram_we, ram_addr, ram_din, busy, owner}, 128'd0);
  endtask

  initial begin
    int e;
    int n;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    issue(0, 0, 32'h4,    '0,           0, 32'h12345678);  // single fetch
    issue(1, 1, 32'hC,    32'hDEADBEEF, 0, 32'h0);         // store, rdata unchanged
    issue(1, 0, 32'hC,    '0,           0, 32'hDEADBEEF);  // load back
    issue(1, 0, 32'h6,    '0,           1, 32'hDEADBEEF);  // misaligned
    issue(0, 0, 32'h1000, '0,           1, 32'h12345678);  // out of range

    // contention from reset: grants 0,1,0,1 with one done every 4 cycles
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    p0_req = 1'b1; p0_addr = 32'h4;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'hC;
    @(posedge clk); #1;
    e = cyc;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back((k % 2 == 0) ? {1'b0, 1'b0, 1'b0, 32'h12345678} : {1'b1, 1'b1, 1'b0, 32'hDEADBEEF});
      exp_cyc_q.push_back(e + 2 + 4 * k);
    end
    check("contention_first_owner", {busy, owner}, 2'b10);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (p0_done || p1_done) n++;
    end
    check("contention_done_count", n, 4);
    p0_req = 1'b0;
    p1_req = 1'b0;
    exp_ram_addr = 10'd3;
    @(negedge clk);

    // reset in ISSUE of a store
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("midstore_issue_we", {ram_we, ram_addr}, {1'b1, 10'd8});
    #2 rst = 1'b1;
    #1 check_all_zero("midstore_async_clear");
    p1_req = 1'b0; p1_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ram_addr = '0;
    check("midstore_no_write", mem[8], 32'h0);
    @(negedge clk);
    issue(1, 0, 32'hC,  '0, 0, 32'hDEADBEEF);
    issue(1, 0, 32'h20, '0, 0, 32'h0);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the multi-cycle CPU's single-port data/instruction RAM (32-bit words, 10-bit word address, 1-bit write enable, registered read output). Port 0 serves instruction fetch (read-only). Port 1 serves load/store. The block converts byte addresses to word addresses, rejects misaligned or out-of-range accesses, serialises requests with round-robin fairness, and returns read data through a req/done handshake.

## Interface
- `ADDR_W`, 10: RAM word-address width.
- `DATA_W`, 32: data width.
- `RD_LAT`, 1: RAM read latency in cycles, ≥1. This is the number of READ-state cycles.

- `clk`  in  1  system clock; the RAM uses the same clock on `clka`.
- `rst`  in  1  asynchronous, active-high reset.
- `p0_req`  in  1  fetch request; held until `p0_done`.
- `p0_addr`  in  32  fetch byte address.
- `p0_done`  out  1  one-cycle completion pulse.
- `p0_rdata`  out  DATA_W  fetched word, registered, valid from `p0_done` onward.
- `p0_err`  out  1  valid with `p0_done`; misaligned or out-of-range access.
- `p1_req`  in  1  data request; held until `p1_done`.
- `p1_we`  in  1  1 = store, 0 = load.
- `p1_addr`  in  32  data byte address.
- `p1_wdata`  in  DATA_W  store data.
- `p1_done`, `p1_rdata`, `p1_err`  out  same meaning as the port 0 signals.
- `ram_we`  out  1  RAM `wea`.
- `ram_addr`  out  ADDR_W  RAM `addra`.
- `ram_din`  out  DATA_W  RAM `dina`.
- `ram_dout`  in  DATA_W  RAM `douta`.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  port that owns the current transaction; 0 while idle.

## Operation
- **Registered outputs.** All outputs are registered.
  - Reset value of every output: 0.
  - Reset value of the internal round-robin pointer `last`: 1, so port 0 wins the first tie.
- **FSM states:** IDLE, ISSUE, READ, DONE.
- **IDLE**
  - Samples `p0_req` and `p1_req`.
  - If exactly one request is high, that port is granted.
  - If both are high, the port ≠ `last` is granted.
  - On grant: latch `owner`, address, we (port 0 is always a read), and wdata; set `last` = owner.
  - If `addr[1:0]` ≠ 0 or `addr[31:ADDR_W+2]` ≠ 0: set an error flag and go to DONE. No RAM access occurs.
  - Otherwise go to ISSUE.
- **ISSUE** (1 cycle)
  - `ram_addr` = `addr[ADDR_W+1:2]`, `ram_din` = wdata, `ram_we` = we.
  - Go to READ with a wait counter loaded to `RD_LAT`-1.
- **READ** (`RD_LAT` cycles)
  - `ram_we` = 0; `ram_addr` is held.
  - On the last cycle, load `ram_dout` into the owner's `rdata` register. This happens for reads only; stores leave `rdata` unchanged.
  - Go to DONE.
- **DONE** (1 cycle)
  - The owner's `done` = 1 and `err` = the error flag. The other port's outputs stay 0.
  - Go to IDLE unconditionally. Requests are not sampled in DONE.
- **Requester rules**
  - A requester must drop `req` by the edge that ends its `done` cycle. If `req` is still high when IDLE next samples, it is treated as a new request.
  - Deasserting `req`, or changing `addr`/`we`/`wdata`, after the grant has no effect on the in-flight transaction.
- **Error path.** `err` is asserted only together with `done`. On an error, `rdata` is not updated.
- **Reset mid-operation.** Asynchronously forces IDLE and clears all outputs, so `ram_we` drops immediately. No `done` pulse is issued for the aborted transaction.

## Timing
- Edge 0 is the edge at which IDLE samples `req`.
- Normal access: ISSUE in cycle 1, READ in cycles 2..`RD_LAT`+1, `done` in cycle `RD_LAT`+2, IDLE in the next cycle. With `RD_LAT`=1, `done` is in cycle 3.
- Error access: `done` in cycle 1.
- Back-to-back throughput: one transaction per `RD_LAT`+3 cycles per grant.
- `ram_we` is high for exactly one cycle per store and never during READ or DONE.
- Under continuous contention from both ports, grants alternate strictly 0,1,0,1,...

## Test plan
- **Single fetch.**
  - Stimulus: preload word 1 = 0x12345678. Raise `p0_req` with `p0_addr`=0x4.
  - Required: `ram_addr`=1 in ISSUE, `ram_we`=0 throughout; `p0_done` in cycle 3 with `p0_rdata`=0x12345678 and `p0_err`=0.
- **Store then load.**
  - Stimulus: port 1 stores 0xDEADBEEF at 0x0C, then loads from 0x0C.
  - Required: `ram_we`=1 for exactly one cycle with `ram_addr`=3 and `ram_din`=0xDEADBEEF; the load returns 0xDEADBEEF; `p1_rdata` is unchanged by the store.
- **Simultaneous requests after reset.**
  - Stimulus: `p0_req` and `p1_req` both held high continuously.
  - Required: grant order 0,1,0,1; `owner` matches each grant; `done` pulses alternate, one every 4 cycles; neither port starves.
- **Misaligned access.**
  - Stimulus: port 1 load at 0x6.
  - Required: `p1_done` and `p1_err` high in cycle 1, no `ram_we`/`ram_addr` activity, `p1_rdata` unchanged.
- **Out-of-range access.**
  - Stimulus: port 0 fetch at 0x1000.
  - Required: `p0_err`=1 in cycle 1.
- **Reset mid-store.**
  - Stimulus: assert `rst` asynchronously during ISSUE of a port 1 store.
  - Required: `ram_we` falls without waiting for a clock edge; all outputs are 0; no `done` pulse; after reset release the next request completes normally.
